vector_unit_ctrl: RTL and testbench

- Sequences one vector-unit job: accepts ARR_WIDTH-wide rows from the systolic array and issues matching reads to the Intermediate and Recurrence SRAMs.
- Aligns the systolic-array row with the returning SRAM data, drives vector-unit enable/mode, and tracks in-flight rows through the vector-unit pipeline.
- Writes each vec_out row back to the Recurrence SRAM (or an output region) and signals done.
- Sits between the top-level layer scheduler, both SRAMs and the vector unit.

---
 rtl/vu_pkg.sv | 18 +
 rtl/vector_unit_ctrl_if.sv | 61 ++++++
 rtl/vu_valid_pipe.sv | 24 ++
 rtl/vector_unit_ctrl.sv | 140 ++++++++++++++
 tb/tb_vector_unit_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vu_pkg.sv
// rtl/vu_pkg.sv - shared types and defaults for the vector-unit controller
package vu_pkg;

    localparam int ARR_WIDTH  = 4;
    localparam int FXP_N      = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int ROW_W      = ARR_WIDTH * FXP_N;

    typedef logic [ARR_WIDTH-1:0][FXP_N-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/vector_unit_ctrl_if.sv
// rtl/vector_unit_ctrl_if.sv - scheduler, SRAM and vector-unit signals of the controller (VU_CTRL_PERF_EN adds perf_stall_cnt)
interface vector_unit_ctrl_if #(
    parameter int ADDR_W = vu_pkg::ADDR_W_DEF
) ();
    import vu_pkg::*;

    // scheduler job request and status
    logic              start;
    logic              cfg_mode;
    logic [ADDR_W:0]   cfg_num_rows;
    logic [ADDR_W-1:0] cfg_int_base;
    logic [ADDR_W-1:0] cfg_rec_base;
    logic [ADDR_W-1:0] cfg_out_base;
    logic              busy;
    logic              done;

    // systolic-array row stream
    logic              sa_row_valid;
    logic              sa_row_ready;
    row_t              sa_row_data;

    // SRAM read ports
    logic              int_re;
    logic              rec_re;
    logic [ADDR_W-1:0] int_raddr;
    logic [ADDR_W-1:0] rec_raddr;

    // vector unit control and write-back
    row_t              vu_sa_row;
    logic              vu_enable;
    logic              vu_mode;
    logic              out_we;
    logic [ADDR_W-1:0] out_waddr;

`ifdef VU_CTRL_PERF_EN
    logic [15:0]       perf_stall_cnt;
`endif

    // environment side: scheduler, array and memories
    modport master (
        output start, cfg_mode, cfg_num_rows, cfg_int_base, cfg_rec_base, cfg_out_base,
        output sa_row_valid, sa_row_data,
        input  sa_row_ready, int_re, rec_re, int_raddr, rec_raddr,
        input  vu_sa_row, vu_enable, vu_mode, out_we, out_waddr, busy, done
`ifdef VU_CTRL_PERF_EN
        , input perf_stall_cnt
`endif
    );

    // controller side
    modport slave (
        input  start, cfg_mode, cfg_num_rows, cfg_int_base, cfg_rec_base, cfg_out_base,
        input  sa_row_valid, sa_row_data,
        output sa_row_ready, int_re, rec_re, int_raddr, rec_raddr,
        output vu_sa_row, vu_enable, vu_mode, out_we, out_waddr, busy, done
`ifdef VU_CTRL_PERF_EN
        , output perf_stall_cnt
`endif
    );

endinterface

// File: rtl/vu_valid_pipe.sv
// rtl/vu_valid_pipe.sv - fixed-depth valid shift register tracking rows through the vector unit
module vu_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic tail_o
);

    logic [DEPTH-1:0] pipe_q;

    // shift one slot per cycle; empty slots carry bubbles to the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | DEPTH'(valid_i);
        end
    end

    assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vector_unit_ctrl.sv
// rtl/vector_unit_ctrl.sv - vector-unit job sequencer (VU_CTRL_PERF_EN adds the stall counter)
module vector_unit_ctrl
    import vu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int VU_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    vector_unit_ctrl_if.slave bus
);

    ctrl_state_e       state_q;
    logic              mode_q;
    logic [ADDR_W:0]   num_rows_q;
    logic [ADDR_W:0]   acc_cnt_q;
    logic [ADDR_W:0]   wr_cnt_q;
    logic [ADDR_W:0]   wr_cnt_d;
    logic [ADDR_W:0]   acc_cnt_d;
    logic [ADDR_W-1:0] int_base_q;
    logic [ADDR_W-1:0] rec_base_q;
    logic [ADDR_W-1:0] out_base_q;
    row_t              vu_sa_row_q;
    logic              vu_enable_q;
    logic              done_q;
    logic              sa_ready;
    logic              accept;
    logic              wr_strobe;
`ifdef VU_CTRL_PERF_EN
    logic [15:0]       perf_stall_cnt_q;
`endif

    // reads issue in the accept cycle so SRAM data lines up with vu_sa_row one cycle later
    assign sa_ready  = (state_q == RUN) && (acc_cnt_q < num_rows_q);
    assign accept    = sa_ready && bus.sa_row_valid;
    assign acc_cnt_d = acc_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    assign wr_cnt_d  = wr_cnt_q + {{ADDR_W{1'b0}}, wr_strobe};

    assign bus.sa_row_ready = sa_ready;
    assign bus.int_re       = accept;
    assign bus.rec_re       = accept;
    assign bus.int_raddr    = accept ? int_base_q + acc_cnt_q[ADDR_W-1:0] : '0;
    assign bus.rec_raddr    = accept ? rec_base_q + acc_cnt_q[ADDR_W-1:0] : '0;
    assign bus.vu_sa_row    = vu_sa_row_q;
    assign bus.vu_enable    = vu_enable_q;
    assign bus.vu_mode      = mode_q;
    assign bus.out_we       = wr_strobe;
    assign bus.out_waddr    = wr_strobe ? out_base_q + wr_cnt_q[ADDR_W-1:0] : '0;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
`ifdef VU_CTRL_PERF_EN
    assign bus.perf_stall_cnt = perf_stall_cnt_q;
`endif

    // accepted rows surface at the vector-unit output after the SRAM read plus VU_LATENCY
    vu_valid_pipe #(
        .DEPTH (1 + VU_LATENCY)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .tail_o  (wr_strobe)
    );

    // job sequencing: config latch, row/write counting and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            num_rows_q  <= '0;
            acc_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            int_base_q  <= '0;
            rec_base_q  <= '0;
            out_base_q  <= '0;
            vu_sa_row_q <= '0;
            vu_enable_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef VU_CTRL_PERF_EN
            perf_stall_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_q     <= bus.cfg_mode;
                        num_rows_q <= bus.cfg_num_rows;
                        int_base_q <= bus.cfg_int_base;
                        rec_base_q <= bus.cfg_rec_base;
                        out_base_q <= bus.cfg_out_base;
                        acc_cnt_q  <= '0;
                        wr_cnt_q   <= '0;
`ifdef VU_CTRL_PERF_EN
                        perf_stall_cnt_q <= '0;
`endif
                        if (bus.cfg_num_rows == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            vu_enable_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    wr_cnt_q <= wr_cnt_d;
                    if (accept) begin
                        vu_sa_row_q <= bus.sa_row_data;
                        acc_cnt_q   <= acc_cnt_d;
                        if (acc_cnt_d == num_rows_q) begin
                            state_q <= DRAIN;
                        end
                    end
`ifdef VU_CTRL_PERF_EN
                    if (sa_ready && !bus.sa_row_valid && (perf_stall_cnt_q != 16'hFFFF)) begin
                        perf_stall_cnt_q <= perf_stall_cnt_q + 16'd1;
                    end
`endif
                end
                DRAIN: begin
                    // finish as the last row is written so done follows it directly
                    wr_cnt_q <= wr_cnt_d;
                    if (wr_cnt_d == num_rows_q) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        vu_enable_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_unit_ctrl.sv
// tb/tb_vector_unit_ctrl.sv - directed self-checking bench for vector_unit_ctrl
module tb_vector_unit_ctrl;
    import vu_pkg::*;

    localparam int AW   = 8;
    localparam int MAXC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // per-cycle capture: {busy, sa_row_ready, int_re, rec_re, vu_enable, out_we, done}
    logic [6:0]    ctl [0:MAXC];
    logic [AW-1:0] ia  [0:MAXC];
    logic [AW-1:0] ra  [0:MAXC];
    logic [AW-1:0] wa  [0:MAXC];
    row_t          sar [0:MAXC];
    logic          md  [0:MAXC];

    always #5 clk = ~clk;

    vector_unit_ctrl_if #(.ADDR_W(AW)) bus ();

    vector_unit_ctrl #(
        .ADDR_W     (AW),
        .VU_LATENCY (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic row_t pat(input int c);
        row_t r;
        r = '0;
        r[0] = FXP_N'(c);
        r[1] = FXP_N'(16'hC0DE);
        r[ARR_WIDTH-1] = FXP_N'(c * 37 + 5);
        return r;
    endfunction

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input int c);
        @(negedge clk);
        ctl[c] = {bus.busy, bus.sa_row_ready, bus.int_re, bus.rec_re, bus.vu_enable, bus.out_we, bus.done};
        ia[c]  = bus.int_raddr;
        ra[c]  = bus.rec_raddr;
        wa[c]  = bus.out_waddr;
        sar[c] = bus.vu_sa_row;
        md[c]  = bus.vu_mode;
    endtask

    // cycle 0 carries start; cycles 1..ncyc drive valid from vmask[c-1]
    task automatic run_job(input logic [AW:0] n, input logic [AW-1:0] ib, input logic [AW-1:0] rb,
                           input logic [AW-1:0] ob, input logic m, input logic [15:0] vmask,
                           input int ncyc, input int restart_c);
        tick();
        bus.start = 1'b1;
        bus.cfg_mode = m;
        bus.cfg_num_rows = n;
        bus.cfg_int_base = ib;
        bus.cfg_rec_base = rb;
        bus.cfg_out_base = ob;
        bus.sa_row_valid = 1'b0;
        bus.sa_row_data = pat(0);
        samp(0);
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            bus.start = (c == restart_c);
            if (c == restart_c) begin
                bus.cfg_mode = ~m;
                bus.cfg_num_rows = 9'd1;
                bus.cfg_int_base = 8'h80;
                bus.cfg_rec_base = 8'h81;
                bus.cfg_out_base = 8'h82;
            end
            bus.sa_row_valid = vmask[c-1];
            bus.sa_row_data = pat(c);
            samp(c);
        end
        tick();
        bus.start = 1'b0;
        bus.sa_row_valid = 1'b0;
    endtask

    task automatic test_reset();
        samp(0);
        checks++;
        if (ctl[0] !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl[0], 7'b0);
        end
        checks++;
        if ({ia[0], ra[0], wa[0], md[0]} !== 25'b0 || sar[0] !== row_t'(0)) begin
            errors++;
            $display("FAIL reset_data got=%h/%h/%h/%b/%h exp=0", ia[0], ra[0], wa[0], md[0], sar[0]);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [6:0] exp;
        run_job(9'd4, 8'h10, 8'h20, 8'h30, 1'b0, 16'hFFFF, 10, -1);
        for (int c = 0; c <= 10; c++) begin
            exp = {in_rng(c, 1, 8), in_rng(c, 1, 4), in_rng(c, 1, 4), in_rng(c, 1, 4),
                   in_rng(c, 1, 7), in_rng(c, 4, 7), (c == 8)};
            checks++;
            if (ctl[c] !== exp) begin
                errors++;
                $display("FAIL basic_ctl cyc=%0d got=%b exp=%b", c, ctl[c], exp);
            end
            if (in_rng(c, 1, 4)) begin
                checks++;
                if (ia[c] !== 8'(8'h10 + c - 1) || ra[c] !== 8'(8'h20 + c - 1)) begin
                    errors++;
                    $display("FAIL basic_raddr cyc=%0d got=%h/%h exp=%h/%h", c, ia[c], ra[c],
                             8'(8'h10 + c - 1), 8'(8'h20 + c - 1));
                end
            end
            if (in_rng(c, 4, 7)) begin
                checks++;
                if (wa[c] !== 8'(8'h30 + c - 4)) begin
                    errors++;
                    $display("FAIL basic_waddr cyc=%0d got=%h exp=%h", c, wa[c], 8'(8'h30 + c - 4));
                end
            end
            if (in_rng(c, 2, 5)) begin
                checks++;
                if (sar[c] !== pat(c - 1)) begin
                    errors++;
                    $display("FAIL basic_sarow cyc=%0d got=%h exp=%h", c, sar[c], pat(c - 1));
                end
            end
            if (in_rng(c, 1, 8)) begin
                checks++;
                if (md[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_mode cyc=%0d got=%b exp=0", c, md[c]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic [6:0] exp;
        logic       acc;
        logic       wr;
        int         ridx;
        int         widx;
        run_job(9'd3, 8'h40, 8'h50, 8'h60, 1'b1, 16'b0000_0000_0001_1001, 11, -1);
        for (int c = 0; c <= 11; c++) begin
            acc = (c == 1) || (c == 4) || (c == 5);
            wr  = (c == 4) || (c == 7) || (c == 8);
            ridx = (c == 1) ? 0 : ((c == 4) ? 1 : 2);
            widx = (c == 4) ? 0 : ((c == 7) ? 1 : 2);
            exp = {in_rng(c, 1, 9), in_rng(c, 1, 5), acc, acc, in_rng(c, 1, 8), wr, (c == 9)};
            checks++;
            if (ctl[c] !== exp) begin
                errors++;
                $display("FAIL gaps_ctl cyc=%0d got=%b exp=%b", c, ctl[c], exp);
            end
            if (acc) begin
                checks++;
                if (ia[c] !== 8'(8'h40 + ridx) || ra[c] !== 8'(8'h50 + ridx)) begin
                    errors++;
                    $display("FAIL gaps_raddr cyc=%0d got=%h/%h exp=%h/%h", c, ia[c], ra[c],
                             8'(8'h40 + ridx), 8'(8'h50 + ridx));
                end
            end
            if (wr) begin
                checks++;
                if (wa[c] !== 8'(8'h60 + widx)) begin
                    errors++;
                    $display("FAIL gaps_waddr cyc=%0d got=%h exp=%h", c, wa[c], 8'(8'h60 + widx));
                end
            end
            if (c == 2 || c == 5 || c == 6) begin
                checks++;
                if (sar[c] !== pat(c - 1)) begin
                    errors++;
                    $display("FAIL gaps_sarow cyc=%0d got=%h exp=%h", c, sar[c], pat(c - 1));
                end
            end
            if (in_rng(c, 1, 9)) begin
                checks++;
                if (md[c] !== 1'b1) begin
                    errors++;
                    $display("FAIL gaps_mode cyc=%0d got=%b exp=1", c, md[c]);
                end
            end
        end
    endtask

`ifdef VU_CTRL_PERF_EN
    task automatic test_perf();
        run_job(9'd3, 8'h00, 8'h00, 8'h00, 1'b0, 16'b0000_0000_0001_1001, 11, -1);
        checks++;
        if (bus.perf_stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL perf_stall got=%0d exp=2", bus.perf_stall_cnt);
        end
    endtask
`endif

    task automatic test_zero_rows();
        logic [6:0] exp;
        run_job(9'd0, 8'h10, 8'h20, 8'h30, 1'b0, 16'hFFFF, 3, -1);
        for (int c = 0; c <= 3; c++) begin
            exp = (c == 1) ? 7'b1000001 : 7'b0;
            checks++;
            if (ctl[c] !== exp) begin
                errors++;
                $display("FAIL zero_ctl cyc=%0d got=%b exp=%b", c, ctl[c], exp);
            end
        end
    endtask

    task automatic test_restart_ignored();
        logic [6:0] exp;
        run_job(9'd4, 8'h01, 8'h02, 8'h03, 1'b1, 16'hFFFF, 10, 2);
        for (int c = 0; c <= 10; c++) begin
            exp = {in_rng(c, 1, 8), in_rng(c, 1, 4), in_rng(c, 1, 4), in_rng(c, 1, 4),
                   in_rng(c, 1, 7), in_rng(c, 4, 7), (c == 8)};
            checks++;
            if (ctl[c] !== exp) begin
                errors++;
                $display("FAIL restart_ctl cyc=%0d got=%b exp=%b", c, ctl[c], exp);
            end
            if (in_rng(c, 1, 4)) begin
                checks++;
                if (ia[c] !== 8'(8'h01 + c - 1) || ra[c] !== 8'(8'h02 + c - 1)) begin
                    errors++;
                    $display("FAIL restart_raddr cyc=%0d got=%h/%h exp=%h/%h", c, ia[c], ra[c],
                             8'(8'h01 + c - 1), 8'(8'h02 + c - 1));
                end
            end
            if (in_rng(c, 4, 7)) begin
                checks++;
                if (wa[c] !== 8'(8'h03 + c - 4)) begin
                    errors++;
                    $display("FAIL restart_waddr cyc=%0d got=%h exp=%h", c, wa[c], 8'(8'h03 + c - 4));
                end
            end
            if (in_rng(c, 1, 8)) begin
                checks++;
                if (md[c] !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_mode cyc=%0d got=%b exp=1", c, md[c]);
                end
            end
        end
    endtask

    task automatic test_reset_midjob();
        logic [6:0] exp;
        tick();
        bus.start = 1'b1;
        bus.cfg_mode = 1'b1;
        bus.cfg_num_rows = 9'd5;
        bus.cfg_int_base = 8'h11;
        bus.cfg_rec_base = 8'h22;
        bus.cfg_out_base = 8'h33;
        bus.sa_row_valid = 1'b1;
        bus.sa_row_data = pat(1);
        for (int c = 1; c <= 2; c++) begin
            tick();
            bus.start = 1'b0;
            bus.sa_row_data = pat(c + 1);
        end
        tick();
        rst_n = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            samp(c);
            checks++;
            if (ctl[c] !== 7'b0 || {ia[c], ra[c], wa[c], md[c]} !== 25'b0 || sar[c] !== row_t'(0)) begin
                errors++;
                $display("FAIL midrst_outputs cyc=%0d got=%b/%h/%h/%h/%b/%h exp=0", c, ctl[c],
                         ia[c], ra[c], wa[c], md[c], sar[c]);
            end
            if (c < 5) tick();
        end
        tick();
        rst_n = 1'b1;
        bus.sa_row_valid = 1'b0;
        run_job(9'd2, 8'h05, 8'h06, 8'h70, 1'b0, 16'hFFFF, 8, -1);
        for (int c = 0; c <= 8; c++) begin
            exp = {in_rng(c, 1, 6), in_rng(c, 1, 2), in_rng(c, 1, 2), in_rng(c, 1, 2),
                   in_rng(c, 1, 5), in_rng(c, 4, 5), (c == 6)};
            checks++;
            if (ctl[c] !== exp) begin
                errors++;
                $display("FAIL postrst_ctl cyc=%0d got=%b exp=%b", c, ctl[c], exp);
            end
            if (in_rng(c, 4, 5)) begin
                checks++;
                if (wa[c] !== 8'(8'h70 + c - 4)) begin
                    errors++;
                    $display("FAIL postrst_waddr cyc=%0d got=%h exp=%h", c, wa[c], 8'(8'h70 + c - 4));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [6:0]    exp;
        logic [AW-1:0] exp_ia [0:2];
        logic [AW-1:0] exp_wa [0:2];
        exp_ia = '{8'hFF, 8'h00, 8'h01};
        exp_wa = '{8'hFE, 8'hFF, 8'h00};
        run_job(9'd3, 8'hFF, 8'h80, 8'hFE, 1'b0, 16'hFFFF, 8, -1);
        for (int c = 0; c <= 8; c++) begin
            exp = {in_rng(c, 1, 7), in_rng(c, 1, 3), in_rng(c, 1, 3), in_rng(c, 1, 3),
                   in_rng(c, 1, 6), in_rng(c, 4, 6), (c == 7)};
            checks++;
            if (ctl[c] !== exp) begin
                errors++;
                $display("FAIL wrap_ctl cyc=%0d got=%b exp=%b", c, ctl[c], exp);
            end
            if (in_rng(c, 1, 3)) begin
                checks++;
                if (ia[c] !== exp_ia[c-1]) begin
                    errors++;
                    $display("FAIL wrap_raddr cyc=%0d got=%h exp=%h", c, ia[c], exp_ia[c-1]);
                end
            end
            if (in_rng(c, 4, 6)) begin
                checks++;
                if (wa[c] !== exp_wa[c-4]) begin
                    errors++;
                    $display("FAIL wrap_waddr cyc=%0d got=%h exp=%h", c, wa[c], exp_wa[c-4]);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cfg_mode = 1'b0;
        bus.cfg_num_rows = '0;
        bus.cfg_int_base = '0;
        bus.cfg_rec_base = '0;
        bus.cfg_out_base = '0;
        bus.sa_row_valid = 1'b0;
        bus.sa_row_data = '0;
        test_reset();
        test_basic();
        test_gaps();
`ifdef VU_CTRL_PERF_EN
        test_perf();
`endif
        test_zero_rows();
        test_restart_ignored();
        test_reset_midjob();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
